sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the team's sync_fifo.
//  Adds configurable width/depth, fill count, programmable almost-full/empty flags,
//  overflow/underflow error pulses and defined simultaneous read/write behaviour.
//  Sits between a producer and a consumer in one clock domain.
// PARAMETERS
//  WIDTH     32  data word width in bits (>=1)
//  DEPTH     8   number of storage words (>=2, need not be a power of two)
//  AF_LEVEL  6   almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2   almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//  CW = $clog2(DEPTH+1), derived count width (localparam)
// PORTS
//  clock         in   1      rising-edge clock
//  reset         in   1      asynchronous, active-low reset
//  wn            in   1      write request
//  rn            in   1      read request
//  DATAIN        in   WIDTH  write data, sampled on a clock edge with an accepted write
//  DATAOUT       out  WIDTH  read data
//  full          out  1      count == DEPTH
//  empty         out  1      count == 0
//  almost_full   out  1      count >= AF_LEVEL
//  almost_empty  out  1      count <= AE_LEVEL
//  count         out  CW     words currently stored
//  overflow      out  1      1-cycle pulse: write rejected
//  underflow     out  1      1-cycle pulse: read rejected
// BEHAVIOUR
//  - Reset (reset=0, async): wptr=rptr=count=0, DATAOUT=0, overflow=underflow=0;
//    empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared.
//  - Flags are derived combinationally from the registered count, so they update the
//    same edge count does.
//  - wr_ok = wn & (~full | rn); rd_ok = rn & ~empty (evaluated before the edge).
//  - Write when full with a simultaneous read: the read frees a slot, so both are
//    accepted and count is unchanged.
//  - Read when empty with a simultaneous write: the write is accepted; the read is
//    rejected; count goes from 0 to 1.
//  - Edge, wr_ok: mem[wptr] <= DATAIN; wptr <= (wptr==DEPTH-1) ? 0 : wptr+1.
//  - Edge, rd_ok: rptr advances with the same wrap rule.
//  - count <= count + wr_ok - rd_ok; it never exceeds DEPTH and never goes below 0.
//  - overflow  <= wn & ~wr_ok  (registered, high for exactly the next cycle).
//  - underflow <= rn & ~rd_ok  (registered, high for exactly the next cycle).
//  - Rejected operations leave the pointers, count and memory untouched.
//  - Reset asserted mid-operation discards all contents immediately. The first write
//    after reset release lands at address 0.
// CONFIGURATION
//  Macro SYNC_FIFO_FWFT_EN selects the read mode.
//  - Undefined (standard mode): on rd_ok, DATAOUT <= mem[rptr] at the edge
//    (1-cycle read latency). DATAOUT otherwise holds its last value, including when
//    the FIFO is empty.
//  - Defined (first-word-fall-through): DATAOUT = mem[rptr] combinationally whenever
//    ~empty, and 0 when empty. The head word is visible before rn; rn acts as a pop.
//    Flags, count and error pulses are identical in both modes.
// TESTING
//  (WIDTH=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2; run all scenarios in both macro modes)
//  1. Reset, then write 10,15,20,30,35,40,45 -> count=7, almost_full=1 from 6th write,
//     full=0, almost_empty=0 after 3rd write.
//  2. Continue: write 50 -> full=1, count=8. Write 55 with rn=0 -> overflow pulses
//     1 cycle, count=8, 55 is not stored.
//  3. Read 9 times -> DATAOUT sequence 10,15,20,30,35,40,45,50. The 9th read gives
//     underflow=1 for 1 cycle, empty=1, and DATAOUT holds 50 (standard) or is 0 (FWFT).
//  4. While full, wn=rn=1 with DATAIN=99 -> count stays 8, oldest word is read out,
//     99 is read last, and no overflow pulse occurs.
//  5. While empty, wn=rn=1 with DATAIN=7 -> count=1, underflow pulses, and a later
//     read returns 7.
//  6. Pointer wrap: 3 cycles of write 8 / read 8 with values 100+i -> data order is
//     preserved across the wrap. Assert reset mid-burst -> all outputs return to reset
//     values asynchronously, and the next write/read returns the new data.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with count, almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered reads.
module sync_fifo_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wn,
  input  logic             rn,
  input  logic [WIDTH-1:0] DATAIN,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr_ok, rd_ok;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    almost_full = count >= CW'(AF_LEVEL);
    almost_empty = count <= CW'(AE_LEVEL);
    // a read on a full FIFO frees the slot the simultaneous write uses
    wr_ok = wn & (~full | rn);
    rd_ok = rn & ~empty;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= inc(wptr);
      if (rd_ok) rptr <= inc(rptr);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
      overflow <= wn & ~wr_ok;
      underflow <= rn & ~rd_ok;
    end
  always_ff @(posedge clock)
    if (wr_ok) mem[wptr] <= DATAIN;
`ifdef SYNC_FIFO_FWFT_EN
  assign DATAOUT = empty ? '0 : mem[rptr];
`else
  always_ff @(posedge clock or negedge reset)
    if (!reset) DATAOUT <= '0;
    else if (rd_ok) DATAOUT <= mem[rptr];
`endif
endmodule
